// File: rtl/pattern_sweep_gen.sv
// Exhaustive odometer-order stimulus generator: sweeps N_CH channels through 0..lim
// (ascending or descending) and emits each combination under a valid/ready handshake.
module pattern_sweep_gen #(
    parameter int N_CH  = 5,
    parameter int WIDTH = 16,
    parameter int IDX_W = N_CH * WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIDTH-1:0]        lim,
    input  logic                    mode,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [N_CH*WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        lim_q, lim_d;
    logic                    mode_q, mode_d;
    logic [N_CH*WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    done_q, done_d;

    logic [N_CH*WIDTH-1:0]   data_step;
    logic                    all_end;

    // Odometer step: the fastest channel (highest index) moves first; a channel
    // sitting at its end value wraps and passes the carry to the next slower one.
    always_comb begin
        logic             carry;
        logic [WIDTH-1:0] ch;
        logic [WIDTH-1:0] end_val;
        logic [WIDTH-1:0] wrap_val;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        carry     = 1'b1;
        ch        = '0;
        end_val   = mode_q ? '0 : lim_q;
        wrap_val  = mode_q ? lim_q : '0;
        all_end   = 1'b1;
        data_step = data_q;
        for (int k = N_CH - 1; k >= 0; k--) begin
            ch = data_q[k*WIDTH +: WIDTH];
            if (ch != end_val) begin
                all_end = 1'b0;
            end
            if (carry) begin
                if (ch == end_val) begin
                    data_step[k*WIDTH +: WIDTH] = wrap_val;
                end else begin
                    data_step[k*WIDTH +: WIDTH] = mode_q ? (ch - 1'b1) : (ch + 1'b1);
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        data_d  = data_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    lim_d   = lim;
                    mode_d  = mode;
                    data_d  = mode ? {N_CH{lim}} : '0;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                // abort wins over a simultaneous accept; the beat is simply not followed.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (all_end) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d = data_step;
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // out_last is qualified by RUN so it stays low while idle with a stale pattern.
    assign out_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign out_last  = (state_q == S_RUN) && all_end;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pattern_sweep_gen.sv
// Directed bench for pattern_sweep_gen: three instances (N_CH = 5, 2, 1) exercised
// through shared per-instance signal arrays, with a base-(lim+1) counting model.
module tb_pattern_sweep_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [3];
    logic        abort_s [3];
    logic        mode_s  [3];
    logic        ready_s [3];
    logic [15:0] lim_s   [3];

    logic        valid_s [3];
    logic        last_s  [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic [79:0] data_s  [3];
    logic [79:0] idx_s   [3];

    wire [79:0] d5, i5;
    wire [31:0] d2, i2;
    wire [15:0] d1, i1;
    wire v5, l5, b5, n5, v2, l2, b2, n2, v1, l1, b1, n1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pattern_sweep_gen #(.N_CH(5), .WIDTH(16)) u5 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]), .lim(lim_s[0]),
        .mode(mode_s[0]), .out_ready(ready_s[0]), .out_valid(v5), .out_data(d5),
        .out_last(l5), .out_idx(i5), .busy(b5), .done(n5));

    pattern_sweep_gen #(.N_CH(2), .WIDTH(16)) u2 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]), .lim(lim_s[1]),
        .mode(mode_s[1]), .out_ready(ready_s[1]), .out_valid(v2), .out_data(d2),
        .out_last(l2), .out_idx(i2), .busy(b2), .done(n2));

    pattern_sweep_gen #(.N_CH(1), .WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .start(start_s[2]), .abort(abort_s[2]), .lim(lim_s[2]),
        .mode(mode_s[2]), .out_ready(ready_s[2]), .out_valid(v1), .out_data(d1),
        .out_last(l1), .out_idx(i1), .busy(b1), .done(n1));

    assign valid_s[0] = v5;  assign valid_s[1] = v2;  assign valid_s[2] = v1;
    assign last_s[0]  = l5;  assign last_s[1]  = l2;  assign last_s[2]  = l1;
    assign busy_s[0]  = b5;  assign busy_s[1]  = b2;  assign busy_s[2]  = b1;
    assign done_s[0]  = n5;  assign done_s[1]  = n2;  assign done_s[2]  = n1;
    assign data_s[0]  = d5;  assign data_s[1]  = {48'h0, d2};  assign data_s[2] = {64'h0, d1};
    assign idx_s[0]   = i5;  assign idx_s[1]   = {48'h0, i2};  assign idx_s[2]  = {64'h0, i1};

    // Beat b is b written in base (lim+1); the least significant digit is the fastest channel.
    function automatic logic [79:0] exp_pattern(input int n_ch, input logic [15:0] lim,
                                                input logic mode, input longint unsigned beat);
        longint unsigned base, b, dig, v;
        logic [79:0] r;
        base = longint'(lim) + 1;
        b    = beat;
        r    = '0;
        for (int k = n_ch - 1; k >= 0; k--) begin
            dig = b % base;
            b   = b / base;
            v   = mode ? (longint'(lim) - dig) : dig;
            r[k*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kill(input int s);
        abort_s[s] = 1'b1;
        ready_s[s] = 1'b0;
        tick();
        abort_s[s] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            n_total++; if (valid_s[s] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", s, valid_s[s]); else n_pass++;
            n_total++; if (data_s[s] !== 80'h0) $display("FAIL reset_data[%0d]: got %h want 0", s, data_s[s]); else n_pass++;
            n_total++; if (last_s[s] !== 1'b0) $display("FAIL reset_last[%0d]: got %b want 0", s, last_s[s]); else n_pass++;
            n_total++; if (idx_s[s] !== 80'h0) $display("FAIL reset_idx[%0d]: got %h want 0", s, idx_s[s]); else n_pass++;
            n_total++; if (busy_s[s] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", s, busy_s[s]); else n_pass++;
            n_total++; if (done_s[s] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", s, done_s[s]); else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_first_beats();
        lim_s[0] = 16'd7; mode_s[0] = 1'b0; ready_s[0] = 1'b0; start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n_total++; if (valid_s[0] !== 1'b1) $display("FAIL first_latency: valid got %b want 1", valid_s[0]); else n_pass++;
        n_total++; if (data_s[0] !== 80'h0 || idx_s[0] !== 80'd0) $display("FAIL beat0: data %h idx %0d want 0/0", data_s[0], idx_s[0]); else n_pass++;
        ready_s[0] = 1'b1;
        tick();
        n_total++; if (data_s[0] !== 80'h0001_0000_0000_0000_0000) $display("FAIL beat1: got %h want ch4=1", data_s[0]); else n_pass++;
        for (int i = 0; i < 7; i++) tick();
        n_total++; if (data_s[0] !== 80'h0000_0001_0000_0000_0000 || idx_s[0] !== 80'd8)
            $display("FAIL beat8: data %h idx %0d want ch3=1 idx 8", data_s[0], idx_s[0]); else n_pass++;
        kill(0);
    endtask

    task automatic test_descending();
        logic [31:0] exp_v [5];
        exp_v[0] = 32'h0003_0003; exp_v[1] = 32'h0002_0003; exp_v[2] = 32'h0001_0003;
        exp_v[3] = 32'h0000_0003; exp_v[4] = 32'h0003_0002;
        lim_s[1] = 16'd3; mode_s[1] = 1'b1; start_s[1] = 1'b1;
        tick();
        start_s[1] = 1'b0;
        ready_s[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (data_s[1][31:0] !== exp_v[i]) $display("FAIL desc_beat%0d: got %h want %h", i, data_s[1][31:0], exp_v[i]); else n_pass++;
            tick();
        end
        kill(1);
    endtask

    // Full sweep with the model; ready optionally random. Counts sequence errors and
    // stalled-cycle instability in aggregate, then checks the done handshake.
    task automatic run_sweep(input int s, input int n_ch, input logic [15:0] lim,
                             input logic mode, input logic rnd, input string nm);
        longint unsigned total, beats;
        int bad, stall_bad, budget;
        logic got_last, stalled, r, last_now;
        logic [79:0] pdata, pidx, expv;
        total = 1;
        for (int i = 0; i < n_ch; i++) total = total * (longint'(lim) + 1);
        bad = 0; stall_bad = 0; got_last = 1'b0; stalled = 1'b0; beats = 0;
        pdata = '0; pidx = '0;
        lim_s[s] = lim; mode_s[s] = mode; start_s[s] = 1'b1;
        tick();
        start_s[s] = 1'b0;
        lim_s[s] = ~lim; mode_s[s] = ~mode;
        budget = int'(total) * 4 + 50;
        for (int c = 0; c < budget; c++) begin
            if (valid_s[s] !== 1'b1) begin
                bad++;
                break;
            end
            expv = exp_pattern(n_ch, lim, mode, beats);
            if (data_s[s] !== expv || idx_s[s] !== 80'(beats) || last_s[s] !== (beats == total - 1)) begin
                if (bad == 0) $display("%s first bad beat %0d: data %h idx %0d last %b, model %h", nm, beats, data_s[s], idx_s[s], last_s[s], expv);
                bad++;
            end
            if (stalled && (data_s[s] !== pdata || idx_s[s] !== pidx)) stall_bad++;
            r = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            ready_s[s] = r;
            pdata = data_s[s]; pidx = idx_s[s]; last_now = last_s[s];
            tick();
            stalled = !r;
            if (r) begin
                beats++;
                if (last_now === 1'b1) begin
                    got_last = 1'b1;
                    break;
                end
            end
        end
        ready_s[s] = 1'b0;
        n_total++; if (bad !== 0) $display("FAIL %s_sequence: %0d bad beats, want 0", nm, bad); else n_pass++;
        n_total++; if (stall_bad !== 0) $display("FAIL %s_stall_stable: %0d unstable cycles, want 0", nm, stall_bad); else n_pass++;
        n_total++; if (got_last !== 1'b1 || beats !== total) $display("FAIL %s_beat_count: got %0d (last seen %b) want %0d", nm, beats, got_last, total); else n_pass++;
        expv = exp_pattern(n_ch, lim, mode, total - 1);
        n_total++; if (done_s[s] !== 1'b1 || valid_s[s] !== 1'b0 || busy_s[s] !== 1'b0)
            $display("FAIL %s_done_cycle: done %b valid %b busy %b want 1/0/0", nm, done_s[s], valid_s[s], busy_s[s]); else n_pass++;
        n_total++; if (data_s[s] !== expv || idx_s[s] !== 80'(total - 1))
            $display("FAIL %s_hold_after_done: data %h idx %0d want %h / %0d", nm, data_s[s], idx_s[s], expv, total - 1); else n_pass++;
        tick();
        n_total++; if (done_s[s] !== 1'b0) $display("FAIL %s_done_one_cycle: got %b want 0", nm, done_s[s]); else n_pass++;
    endtask

    task automatic test_restart_in_done();
        lim_s[0] = 16'd0; mode_s[0] = 1'b0; start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n_total++; if (last_s[0] !== 1'b1 || data_s[0] !== 80'h0) $display("FAIL lim0_beat: last %b data %h want 1/0", last_s[0], data_s[0]); else n_pass++;
        ready_s[0] = 1'b1;
        tick();
        ready_s[0] = 1'b0;
        n_total++; if (done_s[0] !== 1'b1) $display("FAIL lim0_done: got %b want 1", done_s[0]); else n_pass++;
        lim_s[0] = 16'd7; start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n_total++; if (valid_s[0] !== 1'b1 || busy_s[0] !== 1'b1 || idx_s[0] !== 80'd0 || done_s[0] !== 1'b0)
            $display("FAIL start_in_done: valid %b busy %b idx %0d done %b want 1/1/0/0", valid_s[0], busy_s[0], idx_s[0], done_s[0]); else n_pass++;
        kill(0);
    endtask

    task automatic test_start_in_run();
        lim_s[0] = 16'd7; mode_s[0] = 1'b0; start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ready_s[0] = 1'b0;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n_total++; if (idx_s[0] !== 80'd3 || data_s[0] !== 80'h0003_0000_0000_0000_0000 || busy_s[0] !== 1'b1)
            $display("FAIL start_in_run: idx %0d data %h busy %b want 3 / ch4=3 / 1", idx_s[0], data_s[0], busy_s[0]); else n_pass++;
        kill(0);
        lim_s[0] = 16'd7; start_s[0] = 1'b1; abort_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0; abort_s[0] = 1'b0;
        n_total++; if (valid_s[0] !== 1'b0) $display("FAIL abort_beats_start: valid got %b want 0", valid_s[0]); else n_pass++;
    endtask

    task automatic test_abort();
        int n, done_seen;
        lim_s[0] = 16'd7; mode_s[0] = 1'b0; start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        n = 0;
        while (idx_s[0] !== 80'd100 && n < 200) begin
            tick();
            n++;
        end
        n_total++; if (idx_s[0] !== 80'd100) $display("FAIL abort_reach_idx100: got %0d want 100", idx_s[0]); else n_pass++;
        abort_s[0] = 1'b1; start_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0; start_s[0] = 1'b0; ready_s[0] = 1'b0;
        n_total++; if (valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || done_s[0] !== 1'b0)
            $display("FAIL abort_stop: valid %b busy %b done %b want 0/0/0", valid_s[0], busy_s[0], done_s[0]); else n_pass++;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done_s[0] !== 1'b0 || valid_s[0] !== 1'b0) done_seen++;
            tick();
        end
        n_total++; if (done_seen !== 0) $display("FAIL abort_quiet: %0d cycles with done/valid, want 0", done_seen); else n_pass++;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        n_total++; if (data_s[0] !== 80'h0 || idx_s[0] !== 80'd0 || valid_s[0] !== 1'b1)
            $display("FAIL abort_restart: data %h idx %0d valid %b want 0/0/1", data_s[0], idx_s[0], valid_s[0]); else n_pass++;
        kill(0);
    endtask

    task automatic test_long_sweeps();
        fork
            run_sweep(0, 5, 16'd7, 1'b0, 1'b0, "asc_5x7");
            run_sweep(2, 1, 16'hFFFF, 1'b0, 1'b0, "full_1xffff");
        join
    endtask

    task automatic test_reset_mid();
        lim_s[0] = 16'd7; mode_s[0] = 1'b1; start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        n_total++; if (valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || last_s[0] !== 1'b0 || done_s[0] !== 1'b0)
            $display("FAIL rst_mid_flags: valid %b busy %b last %b done %b want 0", valid_s[0], busy_s[0], last_s[0], done_s[0]); else n_pass++;
        n_total++; if (data_s[0] !== 80'h0 || idx_s[0] !== 80'h0)
            $display("FAIL rst_mid_data: data %h idx %0d want 0/0", data_s[0], idx_s[0]); else n_pass++;
        rst = 1'b0;
        ready_s[0] = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            start_s[s] = 1'b0; abort_s[s] = 1'b0; mode_s[s] = 1'b0;
            ready_s[s] = 1'b0; lim_s[s] = 16'h0;
        end
        test_reset();
        test_first_beats();
        test_descending();
        run_sweep(1, 2, 16'd3, 1'b1, 1'b1, "desc_2x3");
        run_sweep(0, 5, 16'd0, 1'b0, 1'b0, "lim0_5ch");
        test_restart_in_done();
        test_start_in_run();
        test_abort();
        run_sweep(0, 5, 16'd3, 1'b0, 1'b1, "bp_5x3");
        test_long_sweeps();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
